mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported 16-bit word memory (1-cycle read latency) between two requesters: instruction fetch and data load/store.
- Sits between the pipeline's fetch/memory stages and the mem model, replacing the separate fetch/data/write ports.
- Fixed data-over-fetch priority, with a starvation guard that guarantees fetch progress.
- Supports fetch flush, which kills an in-flight fetch response on a taken branch.

Parameters:
- AW, 15, word address width (byte address bits [15:1])
- DW, 16, data width
- MAX_DATA_STREAK, 4, max consecutive data grants while fetch is waiting (legal range 1..15)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- f_req_valid  in  1  fetch read request
- f_req_addr  in  AW  fetch word address
- f_req_ready  out  1  fetch request granted this cycle
- f_flush  in  1  kill fetch: blocks fetch grant and suppresses f_rsp_valid this cycle
- f_rsp_valid  out  1  fetch read data valid
- f_rsp_data  out  DW  fetch read data
- d_req_valid  in  1  data request
- d_req_we  in  1  1 = store, 0 = load
- d_req_addr  in  AW  data word address
- d_req_wdata  in  DW  store data
- d_req_ready  out  1  data request granted this cycle
- d_rsp_valid  out  1  load data valid (never asserted for stores)
- d_rsp_data  out  DW  load data
- mem_addr  out  AW  memory address (read or write)
- mem_wen  out  1  memory write enable
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after the address is presented

Behaviour:
- Reset (async assert, sync release): rsp_owner = NONE, streak = 0.
  - All ready/rsp_valid/mem_wen outputs = 0 while rst_n = 0.
  - mem_addr and mem_wdata = 0 while rst_n = 0.
- Grant (combinational, at most one per cycle; a transfer occurs when valid && ready):
  - fetch_ok = f_req_valid && !f_flush.
  - Data wins if d_req_valid && !(fetch_ok && streak == MAX_DATA_STREAK).
  - Otherwise fetch wins if fetch_ok.
  - Otherwise no grant: mem_wen = 0, mem_addr holds its last value.
- Mux:
  - mem_addr = address of the granted request.
  - mem_wen = 1 only for a granted store; mem_wdata = d_req_wdata.
- Response state register rsp_owner ∈ {NONE, FETCH, DATA}; next value:
  - FETCH after a fetch grant.
  - DATA after a load grant.
  - NONE after a store grant or no grant.
- Response outputs:
  - f_rsp_valid = (rsp_owner == FETCH) && !f_flush.
  - d_rsp_valid = (rsp_owner == DATA).
  - Both rsp_data outputs = mem_rdata.
- Latency: a read granted in cycle N responds in cycle N+1. Back-to-back grants give one response per cycle, full throughput.
- Streak counter:
  - Increments on a data grant while fetch_ok; saturates at MAX_DATA_STREAK.
  - Clears on a fetch grant or when fetch_ok = 0.
- Write then read: a store in cycle N followed by a load of the same address in N+1 returns the new data. The memory writes at the edge ending cycle N.
- Flush while a fetch response is due: the response is dropped (no f_rsp_valid). A data grant in the same cycle is unaffected.
- A request may change address while not ready. The arbiter does not latch requests; requesters must hold valid/addr until ready.
- Reset asserted mid-operation: any pending response is discarded. No rsp_valid occurs after release until a new grant.

Decomposition:
- Shared package cpu_mem_pkg:
  - Owner enum RSP_NONE = 2'd0, RSP_FETCH = 2'd1, RSP_DATA = 2'd2.
  - Constants AW and DW.
- One natural sub-module, arb_streak_ctr: the saturating streak counter, with inputs inc and clr, and output at_max.

Test Plan:
1. Fetch only: f_req_valid = 1, addresses 0x0000, 0x0001, 0x0002 over three cycles, memory preloaded 0x8041, 0x8052, 0xE010 -> f_req_ready = 1 each cycle; f_rsp_valid with those data in the following cycles; d_rsp_valid = 0.
2. Store then load: store addr 0x0010, data 0x1234, then load addr 0x0010 -> mem_wen = 1 for one cycle; d_rsp_valid = 1 with 0x1234 two cycles after the store grant; no d_rsp_valid for the store.
3. Contention with MAX_DATA_STREAK = 4: both valid continuously -> grant pattern D,D,D,D,F,D,D,D,D,F; the fetch response arrives the cycle after each F.
4. Flush: fetch granted in cycle N; f_flush = 1 in cycle N+1 -> f_rsp_valid = 0 in N+1 and f_req_ready = 0 in N+1. A simultaneous load is granted in N+1 and responds in N+2.
5. Reset mid-load: load granted, rst_n pulsed low before the response cycle -> d_rsp_valid stays 0 and streak = 0 after release. The first fetch after release is granted immediately.
6. Idle then store: no valid for 3 cycles -> mem_wen = 0 and no rsp_valid. A single store to 0x7FFF (top word) writes and produces no response.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and widths for the single-ported memory arbiter.
package cpu_mem_pkg;

  localparam int unsigned AW       = 15;
  localparam int unsigned DW       = 16;
  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,
    RSP_FETCH = 2'd1,
    RSP_DATA  = 2'd2
  } rsp_owner_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of consecutive data grants taken while fetch is waiting.
module arb_streak_ctr
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [STREAK_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != STREAK_W'(MAX))) begin
      count <= count + STREAK_W'(1);
    end
  end

  assign at_max = (count == STREAK_W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word memory between instruction fetch and data
// load/store, data-first with a bounded streak so fetch always progresses.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req_valid,
  input  logic [AW-1:0] f_req_addr,
  output logic          f_req_ready,
  input  logic          f_flush,
  output logic          f_rsp_valid,
  output logic [DW-1:0] f_rsp_data,
  input  logic          d_req_valid,
  input  logic          d_req_we,
  input  logic [AW-1:0] d_req_addr,
  input  logic [DW-1:0] d_req_wdata,
  output logic          d_req_ready,
  output logic          d_rsp_valid,
  output logic [DW-1:0] d_rsp_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  rsp_owner_e    owner_q, owner_d;
  logic [AW-1:0] addr_q;
  logic          fetch_ok;
  logic          at_max;
  logic          d_gnt;
  logic          f_gnt;
  mem_cmd_t      cmd;

  // Grants are gated by rst_n so nothing reaches the memory while in reset.
  assign fetch_ok = f_req_valid && !f_flush;
  assign d_gnt    = rst_n && d_req_valid && !(fetch_ok && at_max);
  assign f_gnt    = rst_n && fetch_ok && !d_gnt;

  assign f_req_ready = f_gnt;
  assign d_req_ready = d_gnt;

  arb_streak_ctr #(
    .MAX (MAX_DATA_STREAK)
  ) u_streak (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (d_gnt && fetch_ok),
    .clr    (f_gnt || !fetch_ok),
    .at_max (at_max)
  );

  // Memory command mux; the address holds its last value on idle cycles.
  always_comb begin
    cmd.addr  = addr_q;
    cmd.wen   = 1'b0;
    cmd.wdata = rst_n ? d_req_wdata : '0;
    if (d_gnt) begin
      cmd.addr = d_req_addr;
      cmd.wen  = d_req_we;
    end else if (f_gnt) begin
      cmd.addr = f_req_addr;
    end
  end

  assign mem_addr  = cmd.addr;
  assign mem_wen   = cmd.wen;
  assign mem_wdata = cmd.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      owner_q <= RSP_NONE;
    end else begin
      addr_q  <= cmd.addr;
      owner_q <= owner_d;
    end
  end

  // Who owns next cycle's read data; stores produce no response.
  always_comb begin
    owner_d = RSP_NONE;
    if (f_gnt) begin
      owner_d = RSP_FETCH;
    end else if (d_gnt && !d_req_we) begin
      owner_d = RSP_DATA;
    end
  end

  assign f_rsp_valid = (owner_q == RSP_FETCH) && !f_flush;
  assign d_rsp_valid = (owner_q == RSP_DATA);
  assign f_rsp_data  = mem_rdata;
  assign d_rsp_data  = mem_rdata;

endmodule
